// File: rtl/s_mux_arbiter_pkg.sv
// s_mux_arbiter_pkg: shared select encodings, FSM states and mod-3 helper
// for the S mux arbiter and its round-robin picker.
package s_mux_arbiter_pkg;
    typedef enum logic {ST_IDLE = 1'b0, ST_OWN = 1'b1} state_e;
    localparam logic [1:0] SEL_D0 = 2'b00;
    localparam logic [1:0] SEL_D1 = 2'b01;
    localparam logic [1:0] SEL_D2 = 2'b10;
    // Next requester index modulo 3; never produces 2'b11.
    function automatic logic [1:0] inc3(input logic [1:0] x);
        return (x == SEL_D2) ? SEL_D0 : x + 2'd1;
    endfunction
endpackage

// File: rtl/rr_pick3.sv
// rr_pick3: combinational 3-way round-robin picker.
//  req    in  3  request vector
//  ptr    in  2  highest-priority index (0..2)
//  winner out 2  first requester at or after ptr (mod 3); SEL_D0 when none
//  any    out 1  at least one request present
module rr_pick3
    import s_mux_arbiter_pkg::*;
(
    input  logic [2:0] req,
    input  logic [1:0] ptr,
    output logic [1:0] winner,
    output logic       any
);
    logic [3:0] req_x;
    logic [1:0] p1, p2;
    // Pad to 4 bits so any 2-bit index stays in range.
    assign req_x = {1'b0, req};
    assign p1 = inc3(ptr);
    assign p2 = inc3(p1);
    assign any = |req;
    assign winner = req_x[ptr] ? ptr : req_x[p1] ? p1 : req_x[p2] ? p2 : SEL_D0;
endmodule

// File: rtl/s_mux_arbiter.sv
// s_mux_arbiter: round-robin sequencer for the 3-input S mux with a 1-entry
// valid/ready output register.
//  clk       in   1      rising-edge clock
//  reset_n   in   1      asynchronous active-low reset
//  req       in   3      per-requester data-present request
//  gnt       out  3      one-hot: word of requester i captured this cycle
//  S_Sel     out  2      S mux select (00=d0, 01=d1, 10=d2)
//  S_mux_out in   WIDTH  S mux output, captured on a grant
//  out_valid out  1      out_data holds a word
//  out_ready in   1      downstream accept
//  out_data  out  WIDTH  captured word
//  busy      out  1      an owner currently holds the S path
module s_mux_arbiter
    import s_mux_arbiter_pkg::*;
#(
    parameter int WIDTH     = 64,
    parameter int BURST_LEN = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       req,
    output logic [2:0]       gnt,
    output logic [1:0]       S_Sel,
    input  logic [WIDTH-1:0] S_mux_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             busy
);
    localparam int CW = $clog2(BURST_LEN + 1);

    state_e           state_q, state_d;
    logic [1:0]       sel_q, sel_d, ptr_q, ptr_d, win;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             valid_q, any, space, own_req, xfer, last;
    logic [WIDTH-1:0] data_q;
    logic [3:0]       req_x;

    rr_pick3 u_pick (.req(req), .ptr(ptr_q), .winner(win), .any(any));

    assign req_x   = {1'b0, req};
    assign own_req = req_x[sel_q];
    // Full throughput: a pop and a push may happen in the same cycle.
    assign space   = !valid_q || out_ready;
    assign xfer    = (state_q == ST_OWN) && own_req && space;
    assign last    = cnt_q == CW'(BURST_LEN - 1);

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        gnt     = '0;
        if (state_q == ST_IDLE) begin
            if (any) begin
                sel_d   = win;
                cnt_d   = '0;
                state_d = ST_OWN;
            end
        end else begin
            if (xfer) begin
                gnt   = 3'b001 << sel_q;
                cnt_d = cnt_q + CW'(1);
            end
            // Leave on burst exhaustion or when the owner withdraws.
            if ((xfer && last) || !own_req) begin
                state_d = ST_IDLE;
                ptr_d   = inc3(sel_q);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            sel_q   <= SEL_D0;
            ptr_q   <= SEL_D0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            if (xfer) begin
                valid_q <= 1'b1;
                data_q  <= S_mux_out;
            end else if (out_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign S_Sel     = sel_q;
    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign busy      = state_q == ST_OWN;
endmodule

// File: tb/tb_s_mux_arbiter.sv
// tb_s_mux_arbiter: tenure-level model plus directed vectors for s_mux_arbiter.
module tb_s_mux_arbiter;
    logic clk = 1'b0, reset_n = 1'b1, out_ready = 1'b1;
    logic [2:0] req, req1 = 3'b000, gnt, gnt1;
    logic [1:0] sel, sel1;
    logic ov, ov1, busy, busy1;
    logic [63:0] od, od1, smo, smo1, d0, d1, d2, dv0, dv1, held;
    int want[3] = '{0, 0, 0};
    int done[3] = '{0, 0, 0};
    int checks = 0, errors = 0, cyc = 0;
    int lw0[$], lc0[$], lw1[$], lc1[$];
    int m_own[2], m_cnt[2], m_ptr[2], m_sel[2];
    logic m_ov[2];
    logic [63:0] m_od[2];
    int e2[13] = '{0, 0, 0, 0, 1, 1, 1, 1, 2, 2, 2, 2, 0};
    int e5[6]  = '{1, 1, 2, 2, 2, 0};
    int e6[4]  = '{0, 1, 0, 1};

    always #5 clk = ~clk;

    assign req = {want[2] > done[2], want[1] > done[1], want[0] > done[0]};
    assign d0 = 64'h1000_0000_0000_0000 + 64'(done[0]);
    assign d1 = 64'h2000_0000_0000_0000 + 64'(done[1]);
    assign d2 = 64'h3000_0000_0000_0000 + 64'(done[2]);
    assign smo  = sel == 2'b00 ? d0 : sel == 2'b01 ? d1 : sel == 2'b10 ? d2 : 64'hDEAD;
    assign smo1 = 64'hC0DE_0000_0000_0000 + 64'(sel1);

    s_mux_arbiter #(.WIDTH(64), .BURST_LEN(4)) dut (
        .clk(clk), .reset_n(reset_n), .req(req), .gnt(gnt), .S_Sel(sel),
        .S_mux_out(smo), .out_valid(ov), .out_ready(out_ready), .out_data(od), .busy(busy));

    s_mux_arbiter #(.WIDTH(64), .BURST_LEN(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .req(req1), .gnt(gnt1), .S_Sel(sel1),
        .S_mux_out(smo1), .out_valid(ov1), .out_ready(1'b1), .out_data(od1), .busy(busy1));

    task automatic chk(string nm, logic [63:0] a, logic [63:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s t=%0t got %h expected %h", nm, $time, a, e);
        end
    endtask

    task automatic mreset(int k);
        m_own[k] = -1; m_cnt[k] = 0; m_ptr[k] = 0; m_sel[k] = 0; m_ov[k] = 1'b0; m_od[k] = '0;
    endtask

    // Expected grant: the current owner is granted when it still requests and the register has room.
    function automatic logic [2:0] eg(int k, logic [2:0] r, logic rdy);
        if (m_own[k] >= 0 && r[m_own[k]] && (!m_ov[k] || rdy)) return 3'b001 << m_own[k];
        return 3'b000;
    endfunction

    task automatic mstep(int k, int bl, logic [2:0] r, logic rdy, logic [63:0] dv);
        logic g;
        g = eg(k, r, rdy) != 3'b000;
        if (m_own[k] < 0) begin
            for (int j = 0; j < 3; j++)
                if (m_own[k] < 0 && r[(m_ptr[k] + j) % 3]) m_own[k] = (m_ptr[k] + j) % 3;
            if (m_own[k] >= 0) begin
                m_sel[k] = m_own[k];
                m_cnt[k] = 0;
            end
        end else begin
            if (g) begin
                m_od[k] = dv; m_ov[k] = 1'b1; m_cnt[k]++;
            end
            if ((g && m_cnt[k] == bl) || !r[m_own[k]]) begin
                m_ptr[k] = (m_own[k] + 1) % 3;
                m_own[k] = -1;
            end
        end
        if (!g && m_ov[k] && rdy) m_ov[k] = 1'b0;
    endtask

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mreset(0);
            mreset(1);
        end else begin
            cyc++;
            dv0 = m_own[0] == 0 ? d0 : m_own[0] == 1 ? d1 : d2;
            dv1 = 64'hC0DE_0000_0000_0000 + 64'(m_own[1] < 0 ? 0 : m_own[1]);
            mstep(0, 4, req, out_ready, dv0);
            mstep(1, 1, req1, 1'b1, dv1);
            for (int i = 0; i < 3; i++) if (gnt[i]) done[i] <= done[i] + 1;
        end
    end

    always @(negedge clk) begin
        chk("sel", sel, 64'(m_sel[0]));
        chk("gnt", gnt, eg(0, req, out_ready));
        chk("busy", busy, 64'(m_own[0] >= 0));
        chk("out_valid", ov, 64'(m_ov[0]));
        chk("out_data", od, m_od[0]);
        chk("sel_not_11", 64'(sel == 2'b11), 0);
        chk("sel1", sel1, 64'(m_sel[1]));
        chk("gnt1", gnt1, eg(1, req1, 1'b1));
        chk("busy1", busy1, 64'(m_own[1] >= 0));
        chk("out_valid1", ov1, 64'(m_ov[1]));
        chk("out_data1", od1, m_od[1]);
        chk("sel1_not_11", 64'(sel1 == 2'b11), 0);
        if (gnt != 3'b000) begin
            lw0.push_back(gnt[2] ? 2 : gnt[1] ? 1 : 0);
            lc0.push_back(cyc);
        end
        if (gnt1 != 3'b000) begin
            lw1.push_back(gnt1[2] ? 2 : gnt1[1] ? 1 : 0);
            lc1.push_back(cyc);
        end
    end

    task automatic give(int i, int n);
        want[i] = done[i] + n;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_log(int which, int n, int budget);
        int t = 0;
        while ((which == 0 ? lw0.size() : lw1.size()) < n && t < budget) begin
            @(negedge clk);
            t++;
        end
        if ((which == 0 ? lw0.size() : lw1.size()) < n) begin
            checks++; errors++;
            $display("FAIL wait_log%0d got %0d grants need %0d", which, which == 0 ? lw0.size() : lw1.size(), n);
        end
    endtask

    task automatic clear_logs();
        lw0.delete(); lc0.delete(); lw1.delete(); lc1.delete();
    endtask

    initial begin
        int t;
        #1 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_valid", ov, 0);
        chk("rst_sel", sel, 0);
        chk("rst_gnt", gnt, 0);
        chk("rst_busy", busy, 0);
        chk("rst_data", od, 0);
        step();
        reset_n = 1'b1;
        repeat (2) step();

        // Three-way contention: bursts of four with one bubble per owner change.
        clear_logs();
        give(0, 5); give(1, 4); give(2, 4);
        wait_log(0, 13, 60);
        for (int i = 0; i < 13; i++) chk($sformatf("t2_owner%0d", i), 64'(lw0[i]), 64'(e2[i]));
        chk("t2_back2back", 64'(lc0[1] - lc0[0]), 1);
        chk("t2_bubble0", 64'(lc0[4] - lc0[3]), 2);
        chk("t2_bubble1", 64'(lc0[8] - lc0[7]), 2);
        chk("t2_bubble2", 64'(lc0[12] - lc0[11]), 2);
        repeat (4) step();

        // Lone requester re-wins after each forced rotation.
        clear_logs();
        give(0, 10);
        wait_log(0, 10, 60);
        chk("t3_count", 64'(lw0.size()), 10);
        chk("t3_burst", 64'(lc0[3] - lc0[0]), 3);
        chk("t3_bubble0", 64'(lc0[4] - lc0[3]), 2);
        chk("t3_bubble1", 64'(lc0[8] - lc0[7]), 2);
        repeat (3) step();
        chk("t3_last_word", od, 64'h1000_0000_0000_000E);

        // Backpressure holds the register and suppresses grants.
        clear_logs();
        out_ready = 1'b0;
        give(1, 3);
        wait_log(0, 1, 20);
        repeat (5) begin
            @(negedge clk);
            chk("t4_stall_gnt", gnt, 0);
            chk("t4_stall_data", od, 64'h2000_0000_0000_0004);
            chk("t4_stall_valid", ov, 1);
        end
        step();
        out_ready = 1'b1;
        @(negedge clk);
        chk("t4_pop_push_gnt", gnt, 3'b010);
        wait_log(0, 3, 20);
        repeat (3) step();
        chk("t4_count", 64'(lw0.size()), 3);
        chk("t4_last_word", od, 64'h2000_0000_0000_0006);

        // Owner 1 withdraws after two words; pointer moves to 2 ahead of 0.
        clear_logs();
        give(1, 2);
        wait_log(0, 1, 20);
        step();
        give(0, 1); give(2, 3);
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (busy && t < 10);
        chk("t5_idle_seen", 64'(busy), 0);
        @(negedge clk);
        chk("t5_sel_d2", sel, 2'b10);
        chk("t5_gnt_d2", gnt, 3'b100);
        wait_log(0, 6, 30);
        for (int i = 0; i < 6; i++) chk($sformatf("t5_owner%0d", i), 64'(lw0[i]), 64'(e5[i]));
        repeat (3) step();

        // Single-word bursts alternate between two requesters.
        clear_logs();
        req1 = 3'b011;
        wait_log(1, 4, 30);
        req1 = 3'b000;
        for (int i = 0; i < 4; i++) chk($sformatf("t6_owner%0d", i), 64'(lw1[i]), 64'(e6[i]));
        chk("t6_bubble", 64'(lc1[1] - lc1[0]), 2);
        repeat (3) step();

        // Asynchronous reset in the middle of a burst.
        give(0, 20);
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!ov && t < 20);
        chk("t1_valid_before", ov, 1);
        step();
        reset_n = 1'b0;
        for (int i = 0; i < 3; i++) want[i] = done[i];
        @(negedge clk);
        chk("t1_rst_valid", ov, 0);
        chk("t1_rst_sel", sel, 0);
        chk("t1_rst_gnt", gnt, 0);
        chk("t1_rst_busy", busy, 0);
        repeat (2) step();
        reset_n = 1'b1;
        give(0, 1);
        @(negedge clk);
        chk("t1_c0_gnt", gnt, 0);
        chk("t1_c0_valid", ov, 0);
        @(negedge clk);
        chk("t1_c1_sel", sel, 2'b00);
        chk("t1_c1_gnt", gnt, 3'b001);
        held = d0;
        @(negedge clk);
        chk("t1_c2_valid", ov, 1);
        chk("t1_c2_data", od, held);
        repeat (3) step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end
endmodule
